// File: rtl/psum_pkg.sv
// Shared types and bank-class range helpers for the psum bank pool manager.
package psum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALLOC = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic {
      CLS_SMALL = 1'b0,
      CLS_BIG   = 1'b1
   } bank_class_e;

   function automatic int unsigned class_base(input bank_class_e cls,
                                              input int unsigned small_count);
      return (cls == CLS_SMALL) ? 32'd0 : small_count;
   endfunction

   function automatic int unsigned class_limit(input bank_class_e cls,
                                               input int unsigned small_count,
                                               input int unsigned total_count);
      return (cls == CLS_SMALL) ? small_count - 32'd1 : total_count - 32'd1;
   endfunction

endpackage

// File: rtl/psum_free_list.sv
// Bank free mask and retained-result mask with lowest-free search inside a class range.
module psum_free_list
   import psum_pkg::*;
#(
   parameter int unsigned SMALL_BANK_COUNT = 3,
   parameter int unsigned BIG_BANK_COUNT   = 3,
   parameter int unsigned ALLOW_PROMOTE    = 0,
   localparam int unsigned TOTAL_BANK_COUNT = SMALL_BANK_COUNT + BIG_BANK_COUNT,
   localparam int unsigned BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  bank_class_e                 alloc_class,
   input  logic                        alloc,
   output logic                        alloc_found_c,
   output logic [BANK_INDEX_WIDTH-1:0] alloc_index_c,
   input  logic                        free_valid,
   input  logic [BANK_INDEX_WIDTH-1:0] free_index,
   input  logic                        retain_valid,
   input  logic [BANK_INDEX_WIDTH-1:0] retain_index,
   input  logic                        release_valid,
   input  logic [BANK_INDEX_WIDTH-1:0] release_index
);

   localparam int unsigned IW = BANK_INDEX_WIDTH;
   localparam int unsigned NB = TOTAL_BANK_COUNT;

   logic [NB-1:0] free_mask, free_mask_d;
   logic [NB-1:0] retained, retained_d;
   logic [IW:0]   class_hit, big_hit;

   // Returns {found, index} of the lowest set bit of mask within [base, limit].
   function automatic logic [IW:0] find_lowest(input logic [NB-1:0] mask,
                                               input int unsigned base,
                                               input int unsigned limit);
      logic [IW:0] hit;
      hit = '0;
      for (int i = int'(NB) - 1; i >= 0; i--) begin
         if (mask[i] && (unsigned'(i) >= base) && (unsigned'(i) <= limit)) begin
            hit = {1'b1, IW'(i)};
         end
      end
      return hit;
   endfunction

   always_comb begin
      class_hit     = find_lowest(free_mask, class_base(alloc_class, SMALL_BANK_COUNT),
                                  class_limit(alloc_class, SMALL_BANK_COUNT, NB));
      big_hit       = find_lowest(free_mask, SMALL_BANK_COUNT, NB - 1);
      alloc_found_c = class_hit[IW];
      alloc_index_c = class_hit[IW-1:0];
      if (!class_hit[IW] && (ALLOW_PROMOTE != 0) && (alloc_class == CLS_SMALL)) begin
         alloc_found_c = big_hit[IW];
         alloc_index_c = big_hit[IW-1:0];
      end
   end

   // Release only frees banks currently held as results; other indices are ignored.
   always_comb begin
      free_mask_d = free_mask;
      retained_d  = retained;
      if (alloc && alloc_found_c) begin
         free_mask_d[alloc_index_c] = 1'b0;
      end
      if (free_valid) begin
         free_mask_d[free_index] = 1'b1;
      end
      if (retain_valid) begin
         retained_d[retain_index] = 1'b1;
      end
      for (int i = 0; i < int'(NB); i++) begin
         if (release_valid && (release_index == IW'(i)) && retained[i]) begin
            retained_d[i]  = 1'b0;
            free_mask_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         free_mask <= '1;
         retained  <= '0;
      end else begin
         free_mask <= free_mask_d;
         retained  <= retained_d;
      end
   end

endmodule

// File: rtl/psum_pool_manager.sv
// Row-by-row psum grid sequencer: allocates one bank per row, reads the previous row, retains the result bank.
module psum_pool_manager
   import psum_pkg::*;
#(
   parameter int unsigned SMALL_BANK_COUNT = 3,
   parameter int unsigned BIG_BANK_COUNT   = 3,
   parameter int unsigned SMALL_THRESHOLD  = 16,
   parameter int unsigned BIG_DEPTH        = 128,
   parameter int unsigned ADDR_WIDTH       = 8,
   parameter int unsigned GPR_WIDTH        = 6,
   parameter int unsigned ALLOW_PROMOTE    = 0,
   localparam int unsigned TOTAL_BANK_COUNT = SMALL_BANK_COUNT + BIG_BANK_COUNT,
   localparam int unsigned BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        new_stage,
   input  logic [ADDR_WIDTH-1:0]       seq1_length,
   input  logic [GPR_WIDTH-1:0]        seq2_length,
   input  logic [GPR_WIDTH-1:0]        operation_id,
   input  logic                        write_enable,
   input  logic                        release_valid,
   input  logic [BANK_INDEX_WIDTH-1:0] release_bank_index,
   output logic [BANK_INDEX_WIDTH-1:0] write_bank_index,
   output logic [ADDR_WIDTH-1:0]       write_address,
   output logic [BANK_INDEX_WIDTH-1:0] read_bank_index,
   output logic [ADDR_WIDTH-1:0]       read_address,
   output logic                        read_bank_valid,
   output logic                        operation_done,
   output logic [GPR_WIDTH-1:0]        done_id,
   output logic [BANK_INDEX_WIDTH-1:0] result_bank_index,
   output logic                        busy,
   output logic                        stall,
   output logic                        error
);

   localparam int unsigned IW = BANK_INDEX_WIDTH;

   state_e                state_q, state_d;
   bank_class_e           cls_q, cls_d;
   logic [ADDR_WIDTH-1:0] s1_q, s1_d, col_q, col_d;
   logic [GPR_WIDTH-1:0]  s2_q, s2_d, id_q, id_d, row_q, row_d;
   logic [IW-1:0]         wbank_q, wbank_d, rbank_q, rbank_d;

   logic                  bad_c, last_col_c, last_row_c, row_end_c;
   logic                  alloc_found_c;
   logic [IW-1:0]         alloc_index_c;

   logic                  busy_d, stall_d, error_d, rbv_d, done_d;
   logic [IW-1:0]         wbi_d, rbi_d, res_d;
   logic [ADDR_WIDTH-1:0] wa_d, ra_d;
   logic [GPR_WIDTH-1:0]  done_id_d;

   assign bad_c      = (seq1_length == '0) || (seq2_length == '0) ||
                       (seq1_length > ADDR_WIDTH'(BIG_DEPTH));
   assign last_col_c = (col_q == s1_q - ADDR_WIDTH'(1));
   assign last_row_c = (row_q == s2_q - GPR_WIDTH'(1));
   assign row_end_c  = (state_q == ST_RUN) && write_enable && last_col_c;

   psum_free_list #(
      .SMALL_BANK_COUNT (SMALL_BANK_COUNT),
      .BIG_BANK_COUNT   (BIG_BANK_COUNT),
      .ALLOW_PROMOTE    (ALLOW_PROMOTE)
   ) u_free_list (
      .clk           (clk),
      .reset         (reset),
      .alloc_class   (cls_q),
      .alloc         (state_q == ST_ALLOC),
      .alloc_found_c (alloc_found_c),
      .alloc_index_c (alloc_index_c),
      .free_valid    (row_end_c && (row_q != '0)),
      .free_index    (rbank_q),
      .retain_valid  (row_end_c && last_row_c),
      .retain_index  (wbank_q),
      .release_valid (release_valid),
      .release_index (release_bank_index)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and datapath next values
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      id_d    = id_q;
      row_d   = row_q;
      col_d   = col_q;
      wbank_d = wbank_q;
      rbank_d = rbank_q;
      case (state_q)
         ST_IDLE: begin
            if (new_stage && !bad_c) begin
               state_d = ST_ALLOC;
               s1_d    = seq1_length;
               s2_d    = seq2_length;
               id_d    = operation_id;
               cls_d   = (seq1_length <= ADDR_WIDTH'(SMALL_THRESHOLD)) ? CLS_SMALL : CLS_BIG;
               row_d   = '0;
            end
         end
         ST_ALLOC: begin
            if (alloc_found_c) begin
               state_d = ST_RUN;
               wbank_d = alloc_index_c;
               col_d   = '0;
            end
         end
         ST_RUN: begin
            if (write_enable) begin
               if (last_col_c) begin
                  col_d = '0;
                  if (last_row_c) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_ALLOC;
                     rbank_d = wbank_q;
                     row_d   = row_q + GPR_WIDTH'(1);
                  end
               end else begin
                  col_d = col_q + ADDR_WIDTH'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output next values, aligned to the state entered on the coming edge
   always_comb begin
      busy_d    = (state_d != ST_IDLE);
      stall_d   = (state_d == ST_ALLOC);
      error_d   = (state_q == ST_IDLE) && new_stage && bad_c;
      wbi_d     = '0;
      wa_d      = '0;
      rbv_d     = 1'b0;
      rbi_d     = '0;
      ra_d      = '0;
      done_d    = 1'b0;
      done_id_d = '0;
      res_d     = '0;
      if (state_d == ST_RUN) begin
         wbi_d = wbank_d;
         wa_d  = col_d;
         if (row_d != '0) begin
            rbv_d = 1'b1;
            rbi_d = rbank_d;
            ra_d  = col_d;
         end
      end
      if (state_d == ST_DONE) begin
         done_d    = 1'b1;
         done_id_d = id_d;
         res_d     = wbank_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cls_q             <= CLS_SMALL;
         s1_q              <= '0;
         s2_q              <= '0;
         id_q              <= '0;
         row_q             <= '0;
         col_q             <= '0;
         wbank_q           <= '0;
         rbank_q           <= '0;
         busy              <= 1'b0;
         stall             <= 1'b0;
         error             <= 1'b0;
         write_bank_index  <= '0;
         write_address     <= '0;
         read_bank_valid   <= 1'b0;
         read_bank_index   <= '0;
         read_address      <= '0;
         operation_done    <= 1'b0;
         done_id           <= '0;
         result_bank_index <= '0;
      end else begin
         cls_q             <= cls_d;
         s1_q              <= s1_d;
         s2_q              <= s2_d;
         id_q              <= id_d;
         row_q             <= row_d;
         col_q             <= col_d;
         wbank_q           <= wbank_d;
         rbank_q           <= rbank_d;
         busy              <= busy_d;
         stall             <= stall_d;
         error             <= error_d;
         write_bank_index  <= wbi_d;
         write_address     <= wa_d;
         read_bank_valid   <= rbv_d;
         read_bank_index   <= rbi_d;
         read_address      <= ra_d;
         operation_done    <= done_d;
         done_id           <= done_id_d;
         result_bank_index <= res_d;
      end
   end

endmodule
